alu2_seq8: RTL

- Sequencing initiator for the team's 4-bit, 2-control-bit ALU. Control-code map: 00 A+B, 01 A+B+1, 10 A&B, 11 A^B.
- Accepts 8-bit commands over a valid/ready handshake.
- Drives the external combinational ALU nibble-by-nibble: low nibble first, then high nibble.
- Rebuilds the carry chain itself, and returns the 8-bit result plus carry and zero flags over a second valid/ready handshake.
- Sits between an instruction/command source and the ALU instance, giving the team 8-bit ADD/SUB/AND/XOR without widening the ALU.

---
 rtl/alu2_seq8_if.sv | 28 ++
 rtl/alu2_seq8.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu2_seq8_if.sv
// Bus bundle for alu2_seq8: command handshake, nibble-wide ALU drive and response handshake.
// slave is the sequencer's view; master is the command source / ALU / consumer side.
interface alu2_seq8_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_c;
    logic [3:0] alu_f;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_c, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_c, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu2_seq8.sv
// 8-bit ADD/SUB/AND/XOR sequencer driving an external 4-bit ALU in two nibble passes,
// rebuilding the carry chain from the ALU result since the ALU has no carry output.
module alu2_seq8 (
    input  logic        clk,
    input  logic        rst_n,
    alu2_seq8_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} op_t;

    state_t     state_q, state_d;
    op_t        op_q;
    logic [7:0] a_q, b_q, res_q;
    logic       carry_q, zero_q;

    logic       arith;
    logic       cin;
    logic       cout;
    logic       cmd_ready_d;
    logic [3:0] alu_a_d, alu_b_d;
    logic [1:0] alu_c_d;

    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_c_d     = '0;
        cin         = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_d = rst_n;
                if (bus.cmd_valid) begin
                    state_d = LO;
                end
            end
            LO: begin
                alu_a_d = a_q[3:0];
                alu_b_d = b_q[3:0];
                alu_c_d = op_q;
                // SUB uses the ALU's +1 code to complete the two's complement of ~B
                cin     = (op_q == OP_SUB);
                state_d = HI;
            end
            HI: begin
                alu_a_d = a_q[7:4];
                alu_b_d = b_q[7:4];
                alu_c_d = arith ? {1'b0, carry_q} : op_q;
                cin     = arith & carry_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A wrapped nibble sum is smaller than A, or equal to A when +1 was added to B=F
    assign cout = arith & ((bus.alu_f < alu_a_d) | (cin & (bus.alu_f == alu_a_d)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q <= op_t'(bus.cmd_op);
                        a_q  <= bus.cmd_a;
                        b_q  <= (op_t'(bus.cmd_op) == OP_SUB) ? ~bus.cmd_b : bus.cmd_b;
                    end
                end
                LO: begin
                    res_q[3:0] <= bus.alu_f;
                    carry_q    <= cout;
                end
                HI: begin
                    res_q[7:4] <= bus.alu_f;
                    carry_q    <= cout;
                    zero_q     <= ({bus.alu_f, res_q[3:0]} == 8'h00);
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_d;
    assign bus.alu_a      = alu_a_d;
    assign bus.alu_b      = alu_b_d;
    assign bus.alu_c      = alu_c_d;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_result = res_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_zero   = zero_q;

endmodule
